// File: rtl/seg_mux_pkg.sv
// rtl/seg_mux_pkg.sv - shared types, constants and helpers for the seven-segment mux driver
//
// Purpose : state encoding, default timing constants, anode-off pattern,
//           anode-enable helper and phase-counter width helper.
// Ports   : none (package).

package seg_mux_pkg;

    typedef enum logic [1:0] {
        SHOW0,
        BLANK0,
        SHOW1,
        BLANK1
    } mux_state_t;

    localparam int SEG_MUX_REFRESH_DEF = 24000;
    localparam int SEG_MUX_BLANK_DEF   = 480;

    localparam logic [1:0] AN_OFF = 2'b11;

    // Active-low enable pattern that lights only digit idx.
    function automatic logic [1:0] an_for(input logic idx);
        logic [1:0] one_hot;
        one_hot = 2'b01 << idx;
        return ~one_hot;
    endfunction

    // Counter must hold the larger of the two terminal counts.
    function automatic int cnt_width(input int refresh_cycles, input int blank_cycles);
        int max_cycles;
        int w;
        max_cycles = (refresh_cycles > blank_cycles) ? refresh_cycles : blank_cycles;
        w = $clog2(max_cycles);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/mux_phase_counter.sv
// rtl/mux_phase_counter.sv - phase counter with clear and terminal-count detect
//
// Purpose : counts cycles spent in the current FSM state; done is high while
//           the count equals the terminal value. Stops at terminal (no wrap).
// Ports   : clk      - system clock
//           reset    - synchronous active-high reset (count to 0)
//           clear    - restart count at 0 on the next edge (state entry)
//           terminal - last count value of the current state
//           done     - count equals terminal; high for one cycle when the
//                      owner clears on done

module mux_phase_counter #(
    parameter int WIDTH = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic [WIDTH-1:0] terminal,
    output logic             done
);

    logic [WIDTH-1:0] cnt_q;
    logic [WIDTH-1:0] cnt_d;

    assign done = (cnt_q == terminal);

    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (!done) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/seg_mux_driver.sv
// rtl/seg_mux_driver.sv - time-multiplexed driver for the dual seven-segment display
//
// Purpose : alternately presents digit0/digit1 on s for the downstream
//           segment decoder and drives the matching active-low anode enables.
//           Define SEG_MUX_BLANK_EN to insert BLANK_CYCLES of dead time
//           (both anodes off) between digits; without it the digits
//           alternate back to back and BLANK_CYCLES is ignored.
// Ports   : clk    - system clock
//           reset  - synchronous active-high reset
//           digit0 - hex value for display digit 0
//           digit1 - hex value for display digit 1
//           s      - digit value to the segment decoder
//           an     - active-low anode enables, an[n] lights digit n
//           sel    - index of the digit currently or most recently shown
//           blank  - high while both anodes are off

module seg_mux_driver
    import seg_mux_pkg::*;
#(
    parameter int REFRESH_CYCLES = SEG_MUX_REFRESH_DEF,
    parameter int BLANK_CYCLES   = SEG_MUX_BLANK_DEF
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] digit0,
    input  logic [3:0] digit1,
    output logic [3:0] s,
    output logic [1:0] an,
    output logic       sel,
    output logic       blank
);

    localparam int CNT_W = cnt_width(REFRESH_CYCLES, BLANK_CYCLES);

    localparam logic [CNT_W-1:0] REFRESH_TERM = CNT_W'(REFRESH_CYCLES - 1);
`ifdef SEG_MUX_BLANK_EN
    localparam logic [CNT_W-1:0] BLANK_TERM   = CNT_W'(BLANK_CYCLES - 1);
`else
    // BLANK1 survives only as the one-cycle reset state.
    localparam logic [CNT_W-1:0] BLANK_TERM   = '0;
`endif

    mux_state_t state_q;
    mux_state_t state_d;

    logic [3:0] s_q;
    logic [3:0] s_d;
    logic [1:0] an_q;
    logic [1:0] an_d;
    logic       sel_q;
    logic       sel_d;
    logic       blank_q;
    logic       blank_d;

    logic [CNT_W-1:0] terminal;
    logic             phase_done;

    // A state change happens exactly when the phase ends, so clearing on
    // done restarts the count on every state entry.
    mux_phase_counter #(
        .WIDTH (CNT_W)
    ) u_phase (
        .clk      (clk),
        .reset    (reset),
        .clear    (phase_done),
        .terminal (terminal),
        .done     (phase_done)
    );

    always_comb begin
        state_d  = state_q;
        s_d      = s_q;
        an_d     = an_q;
        sel_d    = sel_q;
        blank_d  = blank_q;
        terminal = ((state_q == SHOW0) || (state_q == SHOW1)) ? REFRESH_TERM : BLANK_TERM;

        if (phase_done) begin
            unique case (state_q)
`ifdef SEG_MUX_BLANK_EN
                SHOW0:   state_d = BLANK0;
                SHOW1:   state_d = BLANK1;
`else
                SHOW0:   state_d = SHOW1;
                SHOW1:   state_d = SHOW0;
`endif
                BLANK0:  state_d = SHOW1;
                BLANK1:  state_d = SHOW0;
                default: state_d = BLANK1;
            endcase

            // Outputs are loaded on the entry edge of the new state; the
            // digit is captured only here, so mid-slot changes wait for
            // that digit's next slot.
            unique case (state_d)
                SHOW0: begin
                    s_d     = digit0;
                    an_d    = an_for(1'b0);
                    sel_d   = 1'b0;
                    blank_d = 1'b0;
                end
                SHOW1: begin
                    s_d     = digit1;
                    an_d    = an_for(1'b1);
                    sel_d   = 1'b1;
                    blank_d = 1'b0;
                end
                default: begin
                    an_d    = AN_OFF;
                    blank_d = 1'b1;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= BLANK1;
            s_q     <= 4'h0;
            an_q    <= AN_OFF;
            sel_q   <= 1'b0;
            blank_q <= 1'b1;
        end else begin
            state_q <= state_d;
            s_q     <= s_d;
            an_q    <= an_d;
            sel_q   <= sel_d;
            blank_q <= blank_d;
        end
    end

    assign s     = s_q;
    assign an    = an_q;
    assign sel   = sel_q;
    assign blank = blank_q;

endmodule

// File: tb/tb_seg_mux_driver.sv
// tb/tb_seg_mux_driver.sv - self-checking bench for seg_mux_driver

module tb_seg_mux_driver;

    localparam int R = 4;
    localparam int B = 2;
    localparam int P = 2 * (R + B);

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] digit0;
    logic [3:0] digit1;
    logic [3:0] s;
    logic [1:0] an;
    logic       sel;
    logic       blank;

    int n_assert = 0;
    int n_fail   = 0;

    int         e;
    logic [3:0] m_s;
    logic [1:0] m_an;
    logic       m_sel;
    logic       m_blank;

    seg_mux_driver #(
        .REFRESH_CYCLES (R),
        .BLANK_CYCLES   (B)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .digit0 (digit0),
        .digit1 (digit1),
        .s      (s),
        .an     (an),
        .sel    (sel),
        .blank  (blank)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h (edge %0d)", tag, obs, exp, e);
        end
    endtask

    // Reference: position within the display period is derived from the
    // number of edges since reset release.
    task automatic model_edge();
        int t;
        if (reset) begin
            e       = 0;
            m_s     = 4'h0;
            m_sel   = 1'b0;
            m_an    = 2'b11;
            m_blank = 1'b1;
        end else begin
            e++;
`ifdef SEG_MUX_BLANK_EN
            if (e >= B) begin
                t = (e - B) % P;
                if (t == 0) begin
                    m_s = digit0; m_sel = 1'b0;
                end
                if (t == R + B) begin
                    m_s = digit1; m_sel = 1'b1;
                end
                m_blank = !((t < R) || (t >= R + B && t < 2 * R + B));
                m_an    = m_blank ? 2'b11 : (m_sel ? 2'b01 : 2'b10);
            end
`else
            t = (e - 1) % (2 * R);
            if (t == 0) begin
                m_s = digit0; m_sel = 1'b0;
            end
            if (t == R) begin
                m_s = digit1; m_sel = 1'b1;
            end
            m_blank = 1'b0;
            m_an    = m_sel ? 2'b01 : 2'b10;
`endif
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        chk("s", s, m_s);
        chk("an", {2'b00, an}, {2'b00, m_an});
        chk("sel", {3'b000, sel}, {3'b000, m_sel});
        chk("blank", {3'b000, blank}, {3'b000, m_blank});
        n_assert++;
        assert (an !== 2'b00) else begin
            n_fail++;
            $error("FAIL an_never_00: observed %b expected not 00 (edge %0d)", an, e);
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step();
        reset = 1'b0;
    endtask

    initial begin
        reset  = 1'b1;
        digit0 = 4'h3;
        digit1 = 4'hA;
        e      = 0;

        // Reset state
        step();
        step();
        chk("rst_s", s, 4'h0);
        chk("rst_an", {2'b00, an}, 4'b0011);
        chk("rst_blank", {3'b000, blank}, 4'h1);
        reset = 1'b0;

        // Release and the first full period
        for (int i = 0; i < 14; i++) begin
            step();
`ifdef SEG_MUX_BLANK_EN
            if (e == 1) begin
                chk("rel_e1_an", {2'b00, an}, 4'b0011);
                chk("rel_e1_s", s, 4'h0);
            end
            if (e == 2) chk("rel_e2_s", s, 4'h3);
            if (e == 2) chk("rel_e2_an", {2'b00, an}, 4'b0010);
            if (e == 6) chk("rel_e6_blank", {3'b000, blank}, 4'h1);
            if (e == 8) chk("rel_e8_s", s, 4'hA);
            if (e == 8) chk("rel_e8_an", {2'b00, an}, 4'b0001);
            if (e == 12) chk("rel_e12_blank", {3'b000, blank}, 4'h1);
            if (e == 14) chk("rel_e14_s", s, 4'h3);
`else
            if (e == 1) chk("rel_e1_s", s, 4'h3);
            if (e == 1) chk("rel_e1_an", {2'b00, an}, 4'b0010);
            if (e == 5) chk("rel_e5_s", s, 4'hA);
            if (e == 5) chk("rel_e5_an", {2'b00, an}, 4'b0001);
            if (e == 9) chk("rel_e9_s", s, 4'h3);
`endif
        end

        // Stale digit: change digit0 before edge 3
        do_reset();
        step();
        step();
        digit0 = 4'h7;
        for (int i = 0; i < 12; i++) begin
            step();
`ifdef SEG_MUX_BLANK_EN
            if (e == 13) chk("stale_e13_s", s, 4'h3);
            if (e == 14) chk("stale_e14_s", s, 4'h7);
`else
            if (e == 8) chk("stale_e8_s", s, 4'hA);
            if (e == 9) chk("stale_e9_s", s, 4'h7);
`endif
        end

        // Reset in the middle of SHOW1
        digit0 = 4'h3;
        do_reset();
        while (e < 8) step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("midrst_s", s, 4'h0);
        chk("midrst_an", {2'b00, an}, 4'b0011);
        chk("midrst_sel", {3'b000, sel}, 4'h0);
        chk("midrst_blank", {3'b000, blank}, 4'h1);
        step();
`ifdef SEG_MUX_BLANK_EN
        step();
`endif
        chk("midrst_resume_s", s, 4'h3);
        chk("midrst_resume_an", {2'b00, an}, 4'b0010);

        // Equal digits
        digit0 = 4'hF;
        digit1 = 4'hF;
        do_reset();
        for (int i = 0; i < 30; i++) begin
            step();
`ifdef SEG_MUX_BLANK_EN
            if (e >= 2) chk("equal_s", s, 4'hF);
`else
            chk("equal_s", s, 4'hF);
`endif
        end

        // Every digit0 value reaches s during SHOW0
        digit1 = 4'h0;
        for (int v = 0; v < 16; v++) begin
            digit0 = 4'(v);
            do_reset();
`ifdef SEG_MUX_BLANK_EN
            while (e < B) step();
`else
            step();
`endif
            chk("sweep_s", s, 4'(v));
            chk("sweep_an", {2'b00, an}, 4'b0010);
        end

        // Random digits and occasional reset pulses
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(7, 0) == 0) digit0 = 4'($urandom);
            if ($urandom_range(7, 0) == 0) digit1 = 4'($urandom);
            reset = ($urandom_range(199, 0) == 0);
            step();
        end
        reset = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/seg_mux_driver.md
# seg_mux_driver

Time-multiplexed driver for the board's dual seven-segment display. Takes two 4-bit hex digits, alternately presents one at a time on `s` to the downstream `segment` decoder, and drives the matching active-low common-anode enables. Optional dead time between digits suppresses ghosting while the decoder output and anode transistors settle. Sits directly upstream of `segment`; `s` connects to the decoder input, `seg` goes to the pins.

## Interface
- `REFRESH_CYCLES`, 24000: clock cycles each digit is lit (48 MHz HSOSC: 1 kHz per digit); ≥ 2
- `BLANK_CYCLES`, 480: dead-time cycles between digits (10 µs at 48 MHz); ≥ 1; used only with `SEG_MUX_BLANK_EN`
- `clk` in 1: system clock
- `reset` in 1: synchronous, active-high reset
- `digit0` in 4: hex value for display digit 0
- `digit1` in 4: hex value for display digit 1
- `s` out 4: digit value to the `segment` decoder
- `an` out 2: active-low anode enables; `an[n]` lights digit n
- `sel` out 1: index of the digit currently or most recently shown
- `blank` out 1: high while both anodes are off

## Operation
- FSM states: SHOW0 → BLANK0 → SHOW1 → BLANK1 → SHOW0.
- Phase counter: clears on every state entry; counts while in a state. SHOWn exits when counter = REFRESH_CYCLES−1; BLANKn exits when counter = BLANK_CYCLES−1.
- Counter width: `$clog2(max(REFRESH_CYCLES, BLANK_CYCLES))`. Comparison at terminal count only; no wrap past terminal.
- All outputs are registered and update on the state-entry edge:
  - Entering SHOWn: `s` ← `digitn` (sampled that edge), `an` ← `~(2'b01 << n)`, `sel` ← n, `blank` ← 0.
  - Entering BLANKn: `an` ← 2'b11, `blank` ← 1. `s` and `sel` hold.
- Digits are sampled only on SHOW entry. Changes mid-slot appear at that digit's next SHOW entry.
- `an` is never 2'b00 in any cycle.
- Reset values: state BLANK1, counter 0, `s` = 4'h0, `an` = 2'b11, `sel` = 0, `blank` = 1.
- `reset` asserted in any state forces the reset values on the next edge and aborts the current slot. No partial-slot carryover.

## Timing
- Edge 1 is the first rising edge with `reset` low.
- Enabled: SHOW0 is entered at edge BLANK_CYCLES.
- Each SHOWn lasts exactly REFRESH_CYCLES cycles. Each BLANKn lasts exactly BLANK_CYCLES cycles.
- Full period is 2·(REFRESH_CYCLES+BLANK_CYCLES).
- Latency from `digitn` to `s` is one edge, counted from the SHOWn entry edge.

## Configuration
- `SEG_MUX_BLANK_EN` defined:
  - Dead time is inserted as above.
- `SEG_MUX_BLANK_EN` undefined:
  - BLANK0 is removed; SHOW0 → SHOW1 directly.
  - BLANK1 exists only as the reset state and lasts one cycle, so SHOW0 is entered at edge 1.
  - After that, SHOW1 → SHOW0 directly, `blank` stays 0, and the period is 2·REFRESH_CYCLES.
  - `BLANK_CYCLES` is ignored.

## Structure
- Package `seg_mux_pkg`:
  - `typedef enum logic [1:0] {SHOW0, BLANK0, SHOW1, BLANK1} mux_state_t`
  - Default constants `SEG_MUX_REFRESH_DEF`, `SEG_MUX_BLANK_DEF`
  - Anode-off constant `AN_OFF = 2'b11`
- One sub-module, `mux_phase_counter`:
  - Parameterised width.
  - Inputs: `clear`, terminal value. Output: `done` pulse.
- The FSM and output registers stay in `seg_mux_driver`.
- `segment` is instantiated by the top level, not here.

## Test plan
All scenarios use REFRESH_CYCLES=4, BLANK_CYCLES=2; `digit0`=4'h3, `digit1`=4'hA unless noted.
- Reset release, macro on:
  - Edge 1: `an`=11, `blank`=1, `s`=0.
  - Edges 2–5: `s`=3, `an`=10, `sel`=0.
  - Edges 6–7: `an`=11, `blank`=1, `s`=3.
  - Edges 8–11: `s`=A, `an`=01, `sel`=1.
  - Edge 12: blank.
  - Edge 14: `s`=3 again.
- Stale-digit check: set `digit0`=4'h7 before edge 3 → `s` stays 3 through edge 13; `s`=7 at edge 14.
- Reset mid-slot: `reset` high for edge 9 only (during SHOW1) → after edge 9, `an`=11, `blank`=1, `s`=0, `sel`=0; SHOW0 (`s`=3) two edges after release.
- Macro off, same stimulus:
  - Edge 1: `s`=3, `an`=10.
  - Edge 5: `s`=A, `an`=01.
  - Edge 9: `s`=3.
  - `blank`=0 and `an`≠11 after edge 1.
- Equal digits, `digit0`=`digit1`=4'hF, macro on → `s` constant F from edge 2; `an` cycles 10/11/01/11; never 00 (assert every cycle).
- Integration with `segment` across all 16 values of `digit0` (`digit1`=0) → `seg` during SHOW0 matches the decoder table for `digit0`.
